// File: rtl/symbol_feeder.sv
// Symbol feeder: valid/ready FIFO that releases at most one 2-bit symbol per clock to the detector.
// Optional macro SYMBOL_FEEDER_BYPASS_EN lets a push into an empty, unpaused feeder reach num on the same edge.
module symbol_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [1:0]    in_sym,
    output logic          in_ready,
    input  logic          pause,
    input  logic          flush,
    output logic [1:0]    num,
    output logic          num_valid,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          bypass;

    assign in_ready = (level != FULL) && !flush;

    // Idle code 0 completes the handshake but is never stored.
    assign push_req = in_valid && in_ready && (in_sym != 2'd0);
    assign pop      = !pause && (level != '0) && !flush;

`ifdef SYMBOL_FEEDER_BYPASS_EN
    assign bypass = push_req && (level == '0) && !pause;
`else
    assign bypass = 1'b0;
`endif

    assign push = push_req && !bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_sym;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            num       <= 2'd0;
            num_valid <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            num       <= 2'd0;
            num_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // num is cleared whenever nothing is emitted so the detector sees "hold".
            if (pop) begin
                num       <= mem[rd_ptr];
                num_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (bypass) begin
                num       <= in_sym;
                num_valid <= 1'b1;
            end else begin
                num       <= 2'd0;
                num_valid <= 1'b0;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_feeder.sv
// Self-checking bench for symbol_feeder: vector table, corner-case sequences and randomized traffic
// compared against a queue-based reference model.
module tb_symbol_feeder;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [1:0]    in_sym;
    logic          in_ready;
    logic          pause;
    logic          flush;
    logic [1:0]    num;
    logic          num_valid;
    logic [AW:0]   level;

    symbol_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sym    (in_sym),
        .in_ready  (in_ready),
        .pause     (pause),
        .flush     (flush),
        .num       (num),
        .num_valid (num_valid),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] sym;
        logic       p;
        logic       f;
        logic [1:0] exp_num;
        logic       exp_nv;
        int         exp_level;
        logic       exp_ready;
    } vec_t;

    vec_t       tbl [12];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] mq [$];
    logic [1:0] mnum = 2'd0;
    logic       mnv  = 1'b0;
    logic [1:0] sent [$];
    logic [1:0] got [$];
    logic       rdy_seen;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("num", int'(num), int'(mnum));
        check("num_valid", int'(num_valid), int'(mnv));
        check("level", int'(level), mq.size());
    endtask

    // Called just after a falling edge; returns whether the offer was accepted.
    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic p,
                                 input logic f, output logic acc);
        logic exp_ready;
        logic popping;
        logic byp;
        in_valid = v;
        in_sym   = s;
        pause    = p;
        flush    = f;
        #1;
        exp_ready = (mq.size() != DEPTH) && !f;
        rdy_seen  = in_ready;
        check("in_ready", int'(in_ready), int'(exp_ready));
        acc = v && exp_ready;
        if (f) begin
            mq.delete();
            mnum = 2'd0;
            mnv  = 1'b0;
        end else begin
            popping = !p && (mq.size() != 0);
            byp     = 1'b0;
`ifdef SYMBOL_FEEDER_BYPASS_EN
            byp = acc && (s != 2'd0) && !p && (mq.size() == 0);
`endif
            mnum = 2'd0;
            mnv  = 1'b0;
            if (popping) begin
                mnum = mq.pop_front();
                mnv  = 1'b1;
            end
            if (byp) begin
                mnum = s;
                mnv  = 1'b1;
            end
            if (acc && (s != 2'd0)) begin
                sent.push_back(s);
                if (!byp) mq.push_back(s);
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
        if (num_valid) got.push_back(num);
        @(negedge clk);
    endtask

    task automatic compareStreams(input string name);
        int n;
        check({name, "_count"}, got.size(), sent.size());
        n = (got.size() < sent.size()) ? got.size() : sent.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_sym"}, int'(got[i]), int'(sent[i]));
        end
        sent.delete();
        got.delete();
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 3 * DEPTH && (mq.size() != 0 || mnv); i++) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, acc);
        end
        check("drain_empty", int'(level), 0);
    endtask

    initial begin
        logic       acc;
        logic [1:0] s;
        int         pushed;

`ifdef SYMBOL_FEEDER_BYPASS_EN
        tbl[0] = '{1'b1, 2'd1, 1'b0, 1'b0, 2'd1, 1'b1, 0, 1'b1};
        tbl[1] = '{1'b1, 2'd2, 1'b0, 1'b0, 2'd2, 1'b1, 0, 1'b1};
        tbl[2] = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd3, 1'b1, 0, 1'b1};
        tbl[3] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1};
        tbl[4] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1};
`else
        tbl[0] = '{1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1, 1'b1};
        tbl[1] = '{1'b1, 2'd2, 1'b0, 1'b0, 2'd1, 1'b1, 1, 1'b1};
        tbl[2] = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd2, 1'b1, 1, 1'b1};
        tbl[3] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b1, 0, 1'b1};
        tbl[4] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1};
`endif
        tbl[5]  = '{1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1, 1'b1};
        tbl[6]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1, 1'b1};
        tbl[7]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1, 1'b1};
        tbl[8]  = '{1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 2, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 0, 1'b1};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_sym   = 2'd0;
        pause    = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("reset_num", int'(num), 0);
        check("reset_num_valid", int'(num_valid), 0);
        check("reset_level", int'(level), 0);
        check("reset_ready", int'(in_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] vector table: ordered drain and zero drop");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].v, tbl[i].sym, tbl[i].p, tbl[i].f, acc);
            check("tbl_ready", int'(rdy_seen), int'(tbl[i].exp_ready));
            check("tbl_num", int'(num), int'(tbl[i].exp_num));
            check("tbl_num_valid", int'(num_valid), int'(tbl[i].exp_nv));
            check("tbl_level", int'(level), tbl[i].exp_level);
        end
        sent.delete();
        got.delete();

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_num", int'(num), 0);
        check("midrst_num_valid", int'(num_valid), 0);
        check("midrst_level", int'(level), 0);
        check("midrst_ready", int'(in_ready), 1);
        mq.delete();
        mnum = 2'd0;
        mnv  = 1'b0;
        sent.delete();
        got.delete();
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] full and pointer wrap");
        for (int i = 0; i < DEPTH; i++) begin
            s = 2'($urandom_range(1, 3));
            applyStimulus(1'b1, s, 1'b1, 1'b0, acc);
        end
        check("full_level", int'(level), DEPTH);
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, acc);
        check("full_ready", int'(rdy_seen), 0);
        check("full_level_hold", int'(level), DEPTH);
        pushed = 0;
        for (int i = 0; i < 40 && pushed < DEPTH; i++) begin
            s = 2'($urandom_range(1, 3));
            applyStimulus(1'b1, s, 1'b0, 1'b0, acc);
            if (acc) pushed++;
        end
        drain();
        compareStreams("wrap_order");

        $display("[TB] simultaneous push/pop at level 3");
        for (int i = 0; i < 3; i++) begin
            s = 2'($urandom_range(1, 3));
            applyStimulus(1'b1, s, 1'b1, 1'b0, acc);
        end
        for (int i = 0; i < 10; i++) begin
            s = 2'($urandom_range(1, 3));
            applyStimulus(1'b1, s, 1'b0, 1'b0, acc);
            check("simul_level", int'(level), 3);
        end
        drain();
        compareStreams("simul_order");

        $display("[TB] flush and first-symbol latency");
        for (int i = 0; i < 5; i++) begin
            s = 2'($urandom_range(1, 3));
            applyStimulus(1'b1, s, 1'b1, 1'b0, acc);
        end
        check("preflush_level", int'(level), 5);
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, acc);
        check("flush_level", int'(level), 0);
        check("flush_num", int'(num), 0);
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, acc);
`ifdef SYMBOL_FEEDER_BYPASS_EN
        check("bypass_num", int'(num), 3);
        check("bypass_level", int'(level), 0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, acc);
        check("bypass_after", int'(num), 0);
`else
        check("nobypass_num", int'(num), 0);
        check("nobypass_level", int'(level), 1);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, acc);
        check("nobypass_late_num", int'(num), 3);
        check("nobypass_late_valid", int'(num_valid), 1);
`endif
        sent.delete();
        got.delete();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/symbol_feeder.md
Name: symbol_feeder

Overview:
- Upstream stage of the 2-bit sequence detector.
- Buffers 2-bit symbols from a producer through a valid/ready handshake in a small FIFO.
- Releases at most one symbol per clock on a registered `num` bus, which drives the detector's `num` input directly.
- Symbol 0 is the idle code, which the detector treats as "hold". The feeder never stores 0 and drives 0 whenever it has nothing to emit.

Parameters:
- DEPTH, 8: FIFO capacity in symbols. Must be a power of two, at least 2.
- AW, 3: pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers in_sym this cycle.
- in_sym  input  2  offered symbol, 1..3 meaningful, 0 = idle.
- in_ready  output  1  feeder can accept this cycle.
- pause  input  1  consumer stall; no pop while high.
- flush  input  1  synchronous FIFO clear.
- num  output  2  symbol to detector; 0 when nothing is emitted.
- num_valid  output  1  num carries a real popped symbol this cycle.
- level  output  AW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async, any time, including mid-stream):
  - read pointer, write pointer and level go to 0.
  - num goes to 2'b00 and num_valid goes to 0.
  - FIFO contents are don't-care.
- in_ready = (level != DEPTH) && !flush. This is combinational from registered state and flush only.
- Push: in_valid && in_ready && (in_sym != 0).
  - The symbol is written at the write pointer, the pointer increments modulo DEPTH, and the wrap is natural.
- Zero drop: in_valid && in_ready && in_sym == 0.
  - The handshake completes (the producer sees acceptance).
  - Nothing is stored and level is unchanged.
- Pop: !pause && level != 0 && !flush, evaluated on pre-edge state.
  - At the edge, num <= head symbol and num_valid <= 1, and the read pointer increments modulo DEPTH.
- No pop: at the edge, num <= 0 and num_valid <= 0. num never holds a stale symbol, so the detector sees "hold".
- Simultaneous push and pop: both happen and level is unchanged.
  - When full, no push occurs even if a pop happens in the same cycle, because in_ready is low.
  - When empty, no pop occurs even if a push happens in the same cycle; the pushed symbol pops no earlier than the next edge.
- Latency:
  - A symbol accepted at edge k appears on num after edge k+1 at the earliest.
  - Symbols are emitted in FIFO order, one per unpaused cycle.
- Level arithmetic: level increments on push-only, decrements on pop-only, and is otherwise held. It never exceeds DEPTH and never underflows.
- flush (synchronous):
  - pointers and level go to 0, num goes to 0 and num_valid goes to 0 at the edge.
  - flush overrides push and pop in the same cycle.
- pause has no effect on pushes and only blocks pops.

Optional Feature:
- Macro: SYMBOL_FEEDER_BYPASS_EN.
- Defined: when level == 0, !pause, !flush and a non-zero push occurs, the symbol goes straight to num at that edge.
  - num_valid = 1, nothing is written and level stays 0.
  - Minimum latency becomes 1 edge.
- Undefined: there is no bypass and the minimum latency is 2 edges, as described above.

Test Plan:
- Reset mid-stream: push 1,2,3, then assert reset between edges → num = 0, num_valid = 0 and level = 0 immediately, without waiting for clk. Post-reset in_ready = 1.
- Ordered drain: push 1,2,3 on consecutive cycles with pause = 0 → num sequence after the first push edge is 0,1,2,3,0 with num_valid 0,1,1,1,0. The downstream detector then asserts ans.
- Full/wrap: pause = 1 and push 8 symbols → level = 8 and in_ready = 0. A 9th offer is not accepted. Then release pause and push 8 more → emitted order is exact across the pointer wrap.
- Zero drop: offer 1,0,0,2 → in_ready stays 1, level peaks at 2, and the emitted valid sequence is 1,2 only.
- Simultaneous push/pop at level 3: one push plus one pop per cycle for 10 cycles → level stays 3 and no symbol is lost or duplicated.
- Flush plus bypass: flush at level 5 → level = 0 and num = 0 next edge. With SYMBOL_FEEDER_BYPASS_EN, push 3 into empty → num = 3 on the same edge and level stays 0. Without the macro, num = 3 one edge later.
